conv_window_gen: RTL and testbench
==================================

Name: conv_window_gen

Overview:
- Streaming 3x3 sliding-window generator that sits directly upstream of the convolution/MAC datapath orchestrated by `control`.
- Accepts one pixel per handshake in row-major order, holds the two previous image rows in line buffers, and emits one packed 3x3 window per valid position.
- Uses no padding: the window count per frame is (IMG_W-2)*(IMG_H-2).
- A frame is armed by a one-cycle `en` pulse, matching the control block's start convention.

Parameters:
- DATA_W, 8, pixel width in bits.
- IMG_W, 8, image width in pixels (>=3).
- IMG_H, 8, image height in pixels (>=3).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- en  in  1  single-cycle start pulse; arms one frame.
- in_valid  in  1  input pixel valid.
- in_pixel  in  DATA_W  input pixel, row-major.
- in_ready  out  1  block can accept pixel this cycle.
- out_valid  out  1  window valid.
- out_ready  in  1  downstream accepts window.
- out_win  out  9*DATA_W  window; element i at bits [i*DATA_W +: DATA_W], i = 3*r + c, with r=0 the oldest row and c=0 the leftmost column.
- busy  out  1  high when not in IDLE.
- done  out  1  one-cycle pulse when the last window of the frame is accepted.

Behaviour:
- Clocking and reset: one clock domain `clk`. Reset is synchronous and active-high, on `reset`. On reset:
  - state = IDLE
  - row/col counters = 0
  - out_valid = 0, out_win = 0
  - busy = 0, done = 0
  - line buffer contents are don't-care and are not reset.
- FSM states: IDLE, ACTIVE, DRAIN.
  - IDLE: in_ready = 0. en=1 -> ACTIVE, with row=0 and col=0.
  - ACTIVE: pixels are accepted. Accepting pixel (IMG_H-1, IMG_W-1) -> DRAIN.
  - DRAIN: in_ready = 0. The last window is held until out_ready=1. When it is accepted -> IDLE, and done=1 for one cycle.
  - en is ignored outside IDLE.
- Accept and ready rules:
  - Accept when in_valid && in_ready.
  - In ACTIVE, in_ready = !out_valid || out_ready (single output register, full throughput, no bubble).
- On each accept at (row, col):
  - Window shift registers move one column left.
  - The new right column is {lb1[col], lb0[col], in_pixel}, top to bottom.
  - lb1[col] <= lb0[col]; lb0[col] <= in_pixel.
  - col increments and wraps to 0 at IMG_W-1. On wrap, row increments.
- Window emission:
  - A window is generated iff row>=2 && col>=2 at accept.
  - out_win and out_valid are registered: 1-cycle latency from accept to out_valid.
  - Stale columns left over from the previous row are masked by the col>=2 condition. No flush is needed at row boundaries.
- Output hold rules:
  - out_valid && !out_ready: out_win and out_valid are held stable and no pixel is accepted.
  - out_ready && no new window: out_valid clears next cycle.
- Counter widths are $clog2(IMG_W) and $clog2(IMG_H). Counter compares use IMG_W-1 and IMG_H-1 exactly, with no power-of-two assumption.
- Reset mid-frame: aborts the frame immediately. out_valid drops on the next edge, no done pulse is produced, and the block returns to IDLE.
- en coincident with reset: reset wins.
- busy = (state != IDLE).

Optional Feature:
- Macro: CONV_WIN_LAST_EN.
- Defined: adds output port out_last (1 bit), asserted together with out_valid on the final window of a frame, which is the window generated at pixel (IMG_H-1, IMG_W-1). out_last is held with out_win under backpressure and is 0 on reset.
- Undefined: the port is absent. done alone marks the end of a frame.

Decomposition:
- Shared package cnn_pkg:
  - KERNEL_K = 3
  - WIN_ELEMS = 9
  - state encoding typedef for IDLE/ACTIVE/DRAIN
  - default DATA_W
- One natural sub-module: conv_line_buffer, a single-row IMG_W x DATA_W buffer with read-before-write at an index. It is instantiated twice, for lb0 and lb1.

Test Plan (IMG_W=IMG_H=4, DATA_W=8, pixel value = 4*row + col):
- Reset, en pulse, stream 16 pixels with out_ready=1 -> exactly 4 windows. First window = {0,1,2,4,5,6,8,9,10}, last window = {5,6,7,9,10,11,13,14,15}. done pulses one cycle after the last window is accepted. busy=0 afterwards.
- Window timing: the first out_valid rises exactly one cycle after pixel 10 is accepted. No out_valid is produced for pixels 0-9, 12 or 13.
- Backpressure: hold out_ready=0 for 5 cycles while the second window {1,2,3,5,6,7,9,10,11} is valid -> out_win is stable, in_ready=0, no pixel is lost, and the remaining windows are correct.
- Gaps: in_valid toggling 1/0 every cycle -> same 4 windows in the same order.
- Reset asserted after pixel 9 -> out_valid=0 and IDLE next cycle, no done. A new en followed by a full frame produces correct windows.
- en pulses during ACTIVE are ignored. With CONV_WIN_LAST_EN defined, out_last=1 only on the 4th window.

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared constants and state encoding for the CNN front-end blocks.
package cnn_pkg;
  localparam int KERNEL_K       = 3;
  localparam int WIN_ELEMS      = KERNEL_K * KERNEL_K;
  localparam int DEFAULT_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DRAIN  = 2'd2
  } win_state_t;
endpackage

// File: rtl/conv_line_buffer.sv
// Single image row of storage; combinational read and registered write share one index,
// so a read at the write index returns the old contents (read-before-write).
module conv_line_buffer #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] idx,
  input  logic [DATA_W-1:0]        wr_data,
  output logic [DATA_W-1:0]        rd_data
);
  logic [DATA_W-1:0] mem [DEPTH];

  assign rd_data = mem[idx];

  always_ff @(posedge clk) begin
    if (wr_en) mem[idx] <= wr_data;
  end
endmodule

// File: rtl/conv_window_gen.sv
// Streaming 3x3 sliding-window generator (no padding) feeding the conv/MAC datapath.
// Define CONV_WIN_LAST_EN to add the out_last frame-end marker port.
//
//   state  | meaning
//   IDLE   | waiting for an en pulse; no pixels accepted
//   ACTIVE | accepting pixels, emitting windows
//   DRAIN  | last pixel taken; waiting for the final window to be accepted
module conv_window_gen
  import cnn_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        en,
  input  logic                        in_valid,
  input  logic [DATA_W-1:0]           in_pixel,
  output logic                        in_ready,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [WIN_ELEMS*DATA_W-1:0] out_win,
`ifdef CONV_WIN_LAST_EN
  output logic                        out_last,
`endif
  output logic                        busy,
  output logic                        done
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_MIN  = CW'(KERNEL_K - 1);
  localparam logic [RW-1:0] ROW_MIN  = RW'(KERNEL_K - 1);

  win_state_t state, state_next;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic accept, gen_win, last_pix, done_next;
  logic [DATA_W-1:0] lb0_rd, lb1_rd;
  logic [WIN_ELEMS*DATA_W-1:0] win_q, win_next;

  assign in_ready = (state == ACTIVE) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign last_pix = (row == ROW_LAST) && (col == COL_LAST);
  assign gen_win  = (row >= ROW_MIN) && (col >= COL_MIN);
  assign busy     = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      done  <= done_next;
    end
  end

  always_comb begin
    state_next = state;
    done_next  = 1'b0;
    case (state)
      IDLE:    if (en) state_next = ACTIVE;
      ACTIVE:  if (accept && last_pix) state_next = DRAIN;
      DRAIN: begin
        if (out_valid && out_ready) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      row <= '0;
      col <= '0;
    end else if (state == IDLE && en) begin
      row <= '0;
      col <= '0;
    end else if (accept) begin
      if (col == COL_LAST) begin
        col <= '0;
        row <= (row == ROW_LAST) ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  conv_line_buffer #(.DATA_W(DATA_W), .DEPTH(IMG_W)) u_lb0 (
    .clk     (clk),
    .wr_en   (accept),
    .idx     (col),
    .wr_data (in_pixel),
    .rd_data (lb0_rd)
  );

  conv_line_buffer #(.DATA_W(DATA_W), .DEPTH(IMG_W)) u_lb1 (
    .clk     (clk),
    .wr_en   (accept),
    .idx     (col),
    .wr_data (lb0_rd),
    .rd_data (lb1_rd)
  );

  // Shift every row one column left and insert the new right column (oldest row on top).
  always_comb begin
    win_next = '0;
    for (int r = 0; r < KERNEL_K; r++) begin
      for (int c = 0; c < KERNEL_K - 1; c++) begin
        win_next[(r*KERNEL_K + c)*DATA_W +: DATA_W] = win_q[(r*KERNEL_K + c + 1)*DATA_W +: DATA_W];
      end
    end
    win_next[(0*KERNEL_K + KERNEL_K - 1)*DATA_W +: DATA_W] = lb1_rd;
    win_next[(1*KERNEL_K + KERNEL_K - 1)*DATA_W +: DATA_W] = lb0_rd;
    win_next[(2*KERNEL_K + KERNEL_K - 1)*DATA_W +: DATA_W] = in_pixel;
  end

  always_ff @(posedge clk) begin
    if (accept) win_q <= win_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_win   <= '0;
`ifdef CONV_WIN_LAST_EN
      out_last  <= 1'b0;
`endif
    end else if (accept && gen_win) begin
      out_valid <= 1'b1;
      out_win   <= win_next;
`ifdef CONV_WIN_LAST_EN
      out_last  <= last_pix;
`endif
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_conv_window_gen.sv
// Self-checking bench for conv_window_gen on a 4x4 frame with pixel value 4*row+col.
module tb_conv_window_gen;
  import cnn_pkg::*;

  localparam int DW = 8;
  localparam int W  = 4;
  localparam int H  = 4;

  logic clk = 1'b0;
  logic reset, en, in_valid, in_ready, out_valid, out_ready, busy, done;
  logic [DW-1:0] in_pixel;
  logic [9*DW-1:0] out_win;
`ifdef CONV_WIN_LAST_EN
  logic out_last;
`endif

  always #5 clk = ~clk;

  conv_window_gen #(.DATA_W(DW), .IMG_W(W), .IMG_H(H)) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .in_valid  (in_valid),
    .in_pixel  (in_pixel),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_win   (out_win),
`ifdef CONV_WIN_LAST_EN
    .out_last  (out_last),
`endif
    .busy      (busy),
    .done      (done)
  );

  typedef struct {
    int          row;
    int          col;
    logic [71:0] win;
    logic        last;
  } win_rec_t;

  typedef struct {
    int mode;       // 0 stream, 1 gaps, 2 backpressure, 3 abort, 4 en during ACTIVE
    int exp_wins;
    int exp_done;
    bit do_reset;
  } scen_t;

  win_rec_t wtab[4];
  scen_t    stab[6];
  win_rec_t sb_q[$];

  int checks = 0, passes = 0;
  int cyc = 0, pops = 0, dones = 0;
  int p10_cyc, first_ov_cyc, last_pop_cyc, done_cyc;
  logic acc, prev_stall = 1'b0;
  logic [71:0] prev_win = '0;

  function automatic logic [71:0] pack9(input int e0, e1, e2, e3, e4, e5, e6, e7, e8);
    logic [71:0] v;
    v = {e8[7:0], e7[7:0], e6[7:0], e5[7:0], e4[7:0], e3[7:0], e2[7:0], e1[7:0], e0[7:0]};
    return v;
  endfunction

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // One cycle: sample just after the inputs settle (mid low phase), then advance to next negedge.
  task automatic tick();
    #1;
    cyc++;
    if (prev_stall) begin
      chk("hold_valid", out_valid, 1);
      chk("hold_win", out_win, prev_win);
    end
    if (out_valid && !out_ready) chk("stall_in_ready", in_ready, 0);
    prev_stall = out_valid && !out_ready;
    prev_win   = out_win;
    if (out_valid && first_ov_cyc < 0) first_ov_cyc = cyc;
    if (done) begin
      dones++;
      done_cyc = cyc;
    end
    if (out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        chk("spurious_valid", out_valid, 0);
      end else begin
        win_rec_t r;
        r = sb_q.pop_front();
        chk($sformatf("win_%0d_%0d", r.row, r.col), out_win, r.win);
`ifdef CONV_WIN_LAST_EN
        chk($sformatf("last_%0d_%0d", r.row, r.col), out_last, r.last);
`endif
        pops++;
        last_pop_cyc = cyc;
      end
    end
    acc = in_valid && in_ready;
    if (acc) begin
      if (in_pixel == 8'd10) p10_cyc = cyc;
      for (int k = 0; k < 4; k++)
        if (wtab[k].row * W + wtab[k].col == int'(in_pixel)) sb_q.push_back(wtab[k]);
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1; en = 1'b1; in_valid = 1'b0; out_ready = 1'b1; in_pixel = '0;
    tick();
    en = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    sb_q.delete();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_win", out_win, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_in_ready", in_ready, 0);
  endtask

  task automatic run_scen(input int mode);
    int p, hold, budget;
    bit aborted;
    p = 0; hold = 0; budget = 0; aborted = 0;
    pops = 0; dones = 0; p10_cyc = -1; first_ov_cyc = -1; last_pop_cyc = -1; done_cyc = -1;
    en = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    tick();
    en = 1'b0;
    chk("busy_after_en", busy, 1);
    while (p < 16 && budget < 200 && !aborted) begin
      budget++;
      in_pixel = p[7:0];
      in_valid = (mode == 1) ? budget[0] : 1'b1;
      en       = (mode == 4) && (p == 5 || p == 11);
      if (mode == 2 && pops == 1 && out_valid && hold < 5) begin
        out_ready = 1'b0;
        hold++;
      end else begin
        out_ready = 1'b1;
      end
      tick();
      if (acc) p++;
      if (mode == 3 && p == 10) begin
        in_valid = 1'b0; en = 1'b0; out_ready = 1'b1; reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort_out_valid", out_valid, 0);
        chk("abort_busy", busy, 0);
        for (int i = 0; i < 5; i++) tick();
        aborted = 1;
      end
    end
    in_valid = 1'b0; en = 1'b0; out_ready = 1'b1;
    if (aborted) return;
    chk("pixel_budget", p, 16);
    if (mode == 2) chk("stall_cycles", hold, 5);
    for (int i = 0; i < 30 && dones == 0; i++) tick();
    tick();
    chk("done_timing", done_cyc, last_pop_cyc + 1);
    chk("done_one_cycle", done, 0);
    chk("idle_busy", busy, 0);
    chk("first_window_timing", first_ov_cyc, p10_cyc + 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    wtab[0] = '{2, 2, pack9(0, 1, 2, 4, 5, 6, 8, 9, 10),     1'b0};
    wtab[1] = '{2, 3, pack9(1, 2, 3, 5, 6, 7, 9, 10, 11),    1'b0};
    wtab[2] = '{3, 2, pack9(4, 5, 6, 8, 9, 10, 12, 13, 14),  1'b0};
    wtab[3] = '{3, 3, pack9(5, 6, 7, 9, 10, 11, 13, 14, 15), 1'b1};

    stab[0] = '{0, 4, 1, 1'b1};
    stab[1] = '{2, 4, 1, 1'b1};
    stab[2] = '{1, 4, 1, 1'b1};
    stab[3] = '{3, 0, 0, 1'b1};
    stab[4] = '{0, 4, 1, 1'b0};
    stab[5] = '{4, 4, 1, 1'b1};

    reset = 1'b1; en = 1'b0; in_valid = 1'b0; out_ready = 1'b1; in_pixel = '0;
    @(negedge clk);

    for (int s = 0; s < 6; s++) begin
      if (stab[s].do_reset) do_reset();
      run_scen(stab[s].mode);
      chk($sformatf("s%0d_window_count", s), pops, stab[s].exp_wins);
      chk($sformatf("s%0d_done_count", s), dones, stab[s].exp_done);
      chk($sformatf("s%0d_queue_empty", s), sb_q.size(), 0);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
